// File: rtl/adder_cla_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_cla_pipe_if
// Brief    : Operand/result handshake bundle for the pipelined CLA adder.
// Revision : 1.0
// ============================================================================
interface adder_cla_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, A, B, cin, sub, out_ready,
        input  in_ready, out_valid, S, cout, ovf, zero
    );

    modport slave (
        input  in_valid, A, B, cin, sub, out_ready,
        output in_ready, out_valid, S, cout, ovf, zero
    );
endinterface
`default_nettype wire

// File: rtl/adder_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_cla_pipe
// Brief    : Pipelined carry-lookahead adder/subtractor, GPS 4-bit groups per stage.
// Revision : 1.0
// ============================================================================
module adder_cla_pipe #(
    parameter int WIDTH = 16,
    parameter int GPS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    adder_cla_pipe_if.slave  bus
);
    localparam int c_SW = 4 * GPS;
    localparam int c_NS = WIDTH / c_SW;

    // Returns {group G, group P, sum[3:0]} for one 4-bit lookahead group.
    function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        p    = a ^ b;
        g    = a & b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]),
                &p, p ^ c};
    endfunction

    logic w_adv;
    logic r_ovf;
    logic r_zero;

    for (genvar k = 0; k < c_NS; k++) begin : g_stage
        // Stage k sees only operand bits not yet consumed and the sum bits already produced.
        localparam int c_IW = WIDTH - c_SW * k;
        localparam int c_OW = c_SW * (k + 1);

        logic [c_IW-1:0] w_a;
        logic [c_IW-1:0] w_b;
        logic            w_cin;
        logic            w_vin;
        logic [c_SW-1:0] w_slice;
        logic            w_cout;
        logic [c_OW-1:0] w_s;

        logic            r_vld;
        logic            r_c;
        logic [c_OW-1:0] r_s;

        if (k == 0) begin : g_head
            assign w_a   = bus.A;
            assign w_b   = bus.sub ? ~bus.B : bus.B;
            assign w_cin = bus.sub | bus.cin;
            assign w_vin = bus.in_valid;
            assign w_s   = w_slice;
        end else begin : g_body
            assign w_a   = g_stage[k-1].g_fwd.r_a;
            assign w_b   = g_stage[k-1].g_fwd.r_b;
            assign w_cin = g_stage[k-1].r_c;
            assign w_vin = g_stage[k-1].r_vld;
            assign w_s   = {w_slice, g_stage[k-1].r_s};
        end

        always_comb begin
            logic [5:0] w_grp;
            logic       w_c;
            w_grp   = '0;
            w_c     = w_cin;
            w_slice = '0;
            for (int j = 0; j < GPS; j++) begin
                w_grp = cla4(w_a[4*j +: 4], w_b[4*j +: 4], w_c);
                w_slice[4*j +: 4] = w_grp[3:0];
                w_c = w_grp[5] | (w_grp[4] & w_c);
            end
            w_cout = w_c;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_s   <= '0;
            end else if (w_adv) begin
                r_vld <= w_vin;
                r_c   <= w_cout;
                r_s   <= w_s;
            end
        end

        if (k < c_NS - 1) begin : g_fwd
            logic [c_IW-c_SW-1:0] r_a;
            logic [c_IW-c_SW-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a[c_IW-1:c_SW];
                    r_b <= w_b[c_IW-1:c_SW];
                end
            end
        end
    end

    // Carry into the MSB is recovered as a^b^s at that bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv) begin
            r_ovf  <= g_stage[c_NS-1].w_a[c_SW-1] ^ g_stage[c_NS-1].w_b[c_SW-1]
                    ^ g_stage[c_NS-1].w_slice[c_SW-1] ^ g_stage[c_NS-1].w_cout;
            r_zero <= ~|g_stage[c_NS-1].w_s;
        end
    end

    assign w_adv         = ~g_stage[c_NS-1].r_vld | bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = g_stage[c_NS-1].r_vld;
    assign bus.S         = g_stage[c_NS-1].r_s;
    assign bus.cout      = g_stage[c_NS-1].r_c;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_adder_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_cla_pipe
// Brief    : Self-checking bench for adder_cla_pipe at three width/GPS settings.
// Revision : 1.0
// ============================================================================
module tb_adder_cla_pipe;
    localparam int c_NS16 = 4;
    localparam int c_NS32 = 4;
    localparam int c_NS8  = 1;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        v;
        logic        z;
        int          t;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    adder_cla_pipe_if #(.WIDTH(16)) b16 ();
    adder_cla_pipe_if #(.WIDTH(32)) b32 ();
    adder_cla_pipe_if #(.WIDTH(8))  b8  ();

    adder_cla_pipe #(.WIDTH(16), .GPS(1)) u16 (.clk(clk), .rst(rst), .bus(b16));
    adder_cla_pipe #(.WIDTH(32), .GPS(2)) u32 (.clk(clk), .rst(rst), .bus(b32));
    adder_cla_pipe #(.WIDTH(8),  .GPS(2)) u8  (.clk(clk), .rst(rst), .bus(b8));

    // Plain-arithmetic reference: w-bit add/sub with carry, signed overflow, zero.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic sb, input int t);
        exp_t        e;
        logic [64:0] sum;
        logic [63:0] mask;
        logic [63:0] be;
        mask  = (64'd1 << w) - 64'd1;
        be    = (sb ? ~b : b) & mask;
        sum   = {1'b0, a & mask} + {1'b0, be} + {64'd0, sb | ci};
        e.s   = sum[63:0] & mask;
        e.c   = sum[w];
        e.v   = (a[w-1] == be[w-1]) && (e.s[w-1] != a[w-1]);
        e.z   = (e.s == 64'd0);
        e.t   = t;
        return e;
    endfunction

    task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic sb);
        b16.in_valid = v;
        b16.A        = a;
        b16.B        = b;
        b16.cin      = ci;
        b16.sub      = sb;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({b16.out_valid, b16.S, b16.cout, b16.ovf, b16.zero} !== 20'd0 || b16.in_ready !== 1'b1)
            begin n_err++; $display("FAIL reset_state: got v=%b S=%h c=%b o=%b z=%b rdy=%b, want all 0, rdy=1",
                b16.out_valid, b16.S, b16.cout, b16.ovf, b16.zero, b16.in_ready); end
        rst = 1'b0;
        b16.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive16(1'b1, 16'h1000 + 16'(i), 16'h0100, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        e = model(16, 64'h1000, 64'h0100, 1'b0, 1'b0, 0);
        @(negedge clk);
        n_vec++;
        if (b16.out_valid !== 1'b1 || b16.S !== e.s[15:0])
            begin n_err++; $display("FAIL reset_prefill: got v=%b S=%h, want v=1 S=%h", b16.out_valid, b16.S, e.s[15:0]); end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({b16.out_valid, b16.S, b16.cout, b16.ovf, b16.zero} !== 20'd0)
            begin n_err++; $display("FAIL reset_midstream: got v=%b S=%h c=%b o=%b z=%b, want all 0",
                b16.out_valid, b16.S, b16.cout, b16.ovf, b16.zero); end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_vec++;
            if (b16.out_valid !== 1'b0)
                begin n_err++; $display("FAIL reset_stale[%0d]: got out_valid=%b, want 0", c, b16.out_valid); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [15:0] ta [6];
        logic [15:0] tb [6];
        logic [15:0] ts [6];
        logic        tci[6];
        logic        tsb[6];
        logic        tc [6];
        logic        tv [6];
        logic        tz [6];
        ta  = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234, 16'h0003};
        tb  = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0001, 16'h0003};
        tci = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1};
        tsb = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b1};
        ts  = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h1236, 16'h0000};
        tc  = '{1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b1};
        tv  = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0};
        tz  = '{1'b1,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1};
        b16.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive16(1'b1, ta[i], tb[i], tci[i], tsb[i]);
            @(posedge clk);
            #1;
            drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            for (int c = 1; c <= c_NS16; c++) begin
                @(negedge clk);
                n_vec++;
                if (b16.out_valid !== (c == c_NS16))
                    begin n_err++; $display("FAIL dir_latency[%0d] cyc %0d: got out_valid=%b, want %b",
                        i, c, b16.out_valid, (c == c_NS16)); end
                if (c == c_NS16) begin
                    n_vec++;
                    if ({b16.S, b16.cout, b16.ovf, b16.zero} !== {ts[i], tc[i], tv[i], tz[i]})
                        begin n_err++; $display("FAIL dir_result[%0d]: got S=%h c=%b o=%b z=%b, want S=%h c=%b o=%b z=%b",
                            i, b16.S, b16.cout, b16.ovf, b16.zero, ts[i], tc[i], tv[i], tz[i]); end
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        q[$];
        exp_t        e;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        b16.out_ready = 1'b1;
        for (int it = 0; it < 100 + c_NS16; it++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            ci = 1'($urandom);
            sb = 1'($urandom);
            drive16(it < 100, a, b, ci, sb);
            @(negedge clk);
            n_vec++;
            if (b16.out_valid !== (it >= c_NS16))
                begin n_err++; $display("FAIL b2b_valid[%0d]: got %b, want %b", it, b16.out_valid, (it >= c_NS16)); end
            if (b16.out_valid === 1'b1) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra[%0d]: got result S=%h, want none", it, b16.S);
                end else begin
                    e = q.pop_front();
                    if ({b16.S, b16.cout, b16.ovf, b16.zero} !== {e.s[15:0], e.c, e.v, e.z} || e.t != it)
                        begin n_err++; $display("FAIL b2b_data[%0d]: got S=%h c=%b o=%b z=%b, want S=%h c=%b o=%b z=%b at %0d",
                            it, b16.S, b16.cout, b16.ovf, b16.zero, e.s[15:0], e.c, e.v, e.z, e.t); end
                end
            end
            if (b16.in_valid && b16.in_ready) q.push_back(model(16, {48'd0, a}, {48'd0, b}, ci, sb, it + c_NS16));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall();
        exp_t        q[$];
        exp_t        e;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [18:0] held;
        bit          pstall;
        pstall = 1'b0;
        held   = '0;
        for (int it = 0; it < 400; it++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            ci = 1'($urandom);
            sb = 1'($urandom);
            if (it < 300) begin
                drive16(1'($urandom), a, b, ci, sb);
                b16.out_ready = 1'($urandom);
            end else begin
                drive16(1'b0, a, b, ci, sb);
                b16.out_ready = 1'b1;
            end
            @(negedge clk);
            n_vec++;
            if (b16.in_ready !== (!b16.out_valid | b16.out_ready))
                begin n_err++; $display("FAIL stall_inready[%0d]: got %b, want %b", it, b16.in_ready,
                    (!b16.out_valid | b16.out_ready)); end
            if (pstall) begin
                n_vec++;
                if (b16.out_valid !== 1'b1 || {b16.S, b16.cout, b16.ovf} !== held)
                    begin n_err++; $display("FAIL stall_hold[%0d]: got v=%b S/c/o=%h, want v=1 S/c/o=%h",
                        it, b16.out_valid, {b16.S, b16.cout, b16.ovf}, held); end
            end
            if (b16.out_valid === 1'b1 && b16.out_ready === 1'b1) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL stall_dup[%0d]: got result S=%h, want none", it, b16.S);
                end else begin
                    e = q.pop_front();
                    if ({b16.S, b16.cout, b16.ovf, b16.zero} !== {e.s[15:0], e.c, e.v, e.z})
                        begin n_err++; $display("FAIL stall_data[%0d]: got S=%h c=%b o=%b z=%b, want S=%h c=%b o=%b z=%b",
                            it, b16.S, b16.cout, b16.ovf, b16.zero, e.s[15:0], e.c, e.v, e.z); end
                end
            end
            if (b16.in_valid && b16.in_ready) q.push_back(model(16, {48'd0, a}, {48'd0, b}, ci, sb, 0));
            pstall = (b16.out_valid === 1'b1) && (b16.out_ready === 1'b0);
            held   = {b16.S, b16.cout, b16.ovf};
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (q.size() != 0)
            begin n_err++; $display("FAIL stall_loss: got %0d results outstanding, want 0", q.size()); end
    endtask

    task automatic test_params();
        exp_t        q32[$];
        exp_t        q8[$];
        exp_t        e;
        logic [31:0] a32;
        logic [31:0] bb32;
        logic [7:0]  a8;
        logic [7:0]  bb8;
        logic        ci32, sb32, ci8, sb8;
        b32.out_ready = 1'b1;
        b8.out_ready  = 1'b1;
        for (int it = 0; it < 80 + c_NS32; it++) begin
            a32 = $urandom; bb32 = $urandom; ci32 = 1'($urandom); sb32 = 1'($urandom);
            a8  = 8'($urandom); bb8 = 8'($urandom); ci8 = 1'($urandom); sb8 = 1'($urandom);
            b32.in_valid = (it < 80); b32.A = a32; b32.B = bb32; b32.cin = ci32; b32.sub = sb32;
            b8.in_valid  = (it < 80); b8.A  = a8;  b8.B  = bb8;  b8.cin  = ci8;  b8.sub  = sb8;
            @(negedge clk);
            n_vec++;
            if (b32.out_valid !== (it >= c_NS32 && it < 80 + c_NS32))
                begin n_err++; $display("FAIL p32_valid[%0d]: got %b, want %b", it, b32.out_valid,
                    (it >= c_NS32 && it < 80 + c_NS32)); end
            if (b32.out_valid === 1'b1 && q32.size() > 0) begin
                e = q32.pop_front();
                n_vec++;
                if ({b32.S, b32.cout, b32.ovf, b32.zero} !== {e.s[31:0], e.c, e.v, e.z} || e.t != it)
                    begin n_err++; $display("FAIL p32_data[%0d]: got S=%h c=%b o=%b z=%b, want S=%h c=%b o=%b z=%b at %0d",
                        it, b32.S, b32.cout, b32.ovf, b32.zero, e.s[31:0], e.c, e.v, e.z, e.t); end
            end
            n_vec++;
            if (b8.out_valid !== (it >= c_NS8 && it < 80 + c_NS8))
                begin n_err++; $display("FAIL p8_valid[%0d]: got %b, want %b", it, b8.out_valid,
                    (it >= c_NS8 && it < 80 + c_NS8)); end
            if (b8.out_valid === 1'b1 && q8.size() > 0) begin
                e = q8.pop_front();
                n_vec++;
                if ({b8.S, b8.cout, b8.ovf, b8.zero} !== {e.s[7:0], e.c, e.v, e.z} || e.t != it)
                    begin n_err++; $display("FAIL p8_data[%0d]: got S=%h c=%b o=%b z=%b, want S=%h c=%b o=%b z=%b at %0d",
                        it, b8.S, b8.cout, b8.ovf, b8.zero, e.s[7:0], e.c, e.v, e.z, e.t); end
            end
            if (b32.in_valid && b32.in_ready) q32.push_back(model(32, {32'd0, a32}, {32'd0, bb32}, ci32, sb32, it + c_NS32));
            if (b8.in_valid && b8.in_ready)   q8.push_back(model(8, {56'd0, a8}, {56'd0, bb8}, ci8, sb8, it + c_NS8));
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (q32.size() != 0 || q8.size() != 0)
            begin n_err++; $display("FAIL params_loss: got %0d/%0d outstanding, want 0/0", q32.size(), q8.size()); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        b16.out_ready = 1'b1;
        b32.in_valid = 1'b0; b32.A = '0; b32.B = '0; b32.cin = 1'b0; b32.sub = 1'b0; b32.out_ready = 1'b1;
        b8.in_valid  = 1'b0; b8.A  = '0; b8.B  = '0; b8.cin  = 1'b0; b8.sub  = 1'b0; b8.out_ready  = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_params();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/adder_cla_pipe.md
# adder_cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups. Each pipeline stage resolves a configurable number of groups and registers the partial sum and group carry, so wide operands close timing at full clock rate. The block accepts one operation per cycle through a valid/ready handshake, stalls as a whole under output back-pressure, and reports carry-out, signed overflow and zero. It is the datapath successor to the 4-bit combinational lookahead adder, for use in wide arithmetic units.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 4
- GPS, 1, 4-bit groups resolved per pipeline stage; (WIDTH/4) divisible by GPS
- Derived NS = WIDTH/(4*GPS), number of stages = latency in cycles

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- cin  input  1  carry-in, add mode only
- sub  input  1  0: A+B+cin; 1: A-B (A+~B+1, cin ignored)
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- S  output  WIDTH  sum/difference
- cout  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  S == 0

## Operation
- Per group: p = a^b, g = a&b; group carries by full 4-bit lookahead equations; group P = &p, G = lookahead generate; stage chains GPS groups by group P/G from incoming carry.
- Effective B = sub ? ~B : B; effective carry-in = sub ? 1 : cin; both captured at acceptance.
- Stage k (0..NS-1) computes bits [4*GPS*k +: 4*GPS] from carry registered by stage k-1 (stage 0 uses effective carry-in); upper unprocessed operand bits and lower finished sum bits travel with the op in stage registers.
- Each stage holds a valid bit; final stage drives out_valid, S, cout, ovf, zero directly from registers.
- ovf = carry into MSB XOR carry out of MSB; zero computed in final stage from full S.
- Advance enable: adv = !out_valid | out_ready. All stages shift together when adv = 1; when adv = 0 every stage register, including outputs, holds.
- in_ready = adv. Transfer on in: in_valid & in_ready at edge; else a bubble (valid 0) enters stage 0.
- Bubbles propagate; they are not compacted.
- Reset: all valid bits 0; S = 0, cout = 0, ovf = 0, zero = 0, out_valid = 0. in_ready = 1 after reset (follows adv).
- Reset mid-operation discards all in-flight ops; no partial result is emitted.

## Timing
- Latency: op accepted at edge t is presented with out_valid = 1 after edge t+NS-1 (visible during cycle following edge t+NS-1... i.e. NS register stages, first visible NS cycles after acceptance cycle).
- Throughput: one op/cycle while out_ready = 1.
- Back-pressure: out_valid & !out_ready freezes pipeline same cycle; in_ready drops combinationally; S/flags stable until accepted.
- Simultaneous out transfer and new in transfer in same cycle is legal and lossless.
- out_valid = 0 with out_ready = 0 still advances (fills holes).
- Ordering strictly in-order; no op dropped or duplicated.

## Test plan
- Reset: assert rst mid-stream with 3 ops in flight -> out_valid = 0, S = 0, flags 0 immediately; after release no stale result appears.
- Add, WIDTH=16 GPS=1: A=0xFFFF, B=0x0001, cin=0 -> exactly 4 cycles later S=0x0000, cout=1, zero=1, ovf=0.
- Overflow/sub: A=0x7FFF, B=0x0001, sub=0 -> S=0x8000, ovf=1, cout=0; A=0x0005, B=0x0007, sub=1 -> S=0xFFFE, cout=0, ovf=0; A=0x8000, B=0x0001, sub=1 -> S=0x7FFF, ovf=1.
- Back-to-back: 100 random ops, in_valid constant, out_ready=1 -> one result per cycle, in order, matching reference model incl. cout/ovf/zero.
- Stall: random out_ready (50%) and in_valid -> no loss/duplication; S held stable while out_valid & !out_ready; in_ready == (!out_valid | out_ready) every cycle.
- Params: WIDTH=32 GPS=2 (NS=4) and WIDTH=8 GPS=2 (NS=1, latency 1) -> random add/sub against model, latency = NS.
